// File: rtl/dff_bank_arbiter_pkg.sv
// dff_bank_arbiter_pkg: shared types and helpers for the DFF bank arbiter.
// Helpers work on an 8-bit request space, which covers every legal N (2..8).
package dff_bank_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam int MAX_REQ = 8;

  // First requester at or after ptr, wrapping at n; returns a one-hot winner
  // (all zeros when nothing is requesting).
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [2:0] ptr,
                                                 input int n);
    logic [MAX_REQ-1:0] res;
    logic               found;
    logic [2:0]         sel;
    res   = '0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      sel = 3'((int'(ptr) + k) % n);
      if (k < n && !found && req[sel]) begin
        res[sel] = 1'b1;
        found    = 1'b1;
      end
    end
    return res;
  endfunction

  // Index of the set bit in a one-hot vector (0 when the vector is empty).
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (oh[k]) idx = 3'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dff_bank_arbiter_reg.sv
// dff_bank_reg: W-bit D flip-flop bank with synchronous reset and load enable.
module dff_bank_reg #(
  parameter int W = 8
) (
  input  logic         Clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] Q
);

  logic [W-1:0] q_d, q_q;

  // Next bank value: take new data on load, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (load) q_d = d;
  end

  // Bank storage; reset clears the contents and drops any pending load.
  always_ff @(posedge Clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign Q = q_q;

endmodule

// File: rtl/dff_bank_arbiter.sv
// dff_bank_arbiter: round-robin owner arbitration for a shared DFF bank.
// Optional grant timeout is compiled in with DFF_BANK_ARBITER_TIMEOUT_EN.
module dff_bank_arbiter
  import dff_bank_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic           Clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   wr_en,
  input  logic [N*W-1:0] wr_data,
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   Q,
  output logic           busy,
  output logic           timeout
);

  if (N < 2 || N > MAX_REQ) begin : g_bad_n
    $error("dff_bank_arbiter: N must be in 2..8");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("dff_bank_arbiter: MAX_HOLD must be at least 1");
  end

  state_e               state_q, state_d;
  logic [2:0]           ptr_q, ptr_d;
  logic [N-1:0]         gnt_q, gnt_d;
  logic [N-1:0]         req_eff;
  logic [MAX_REQ-1:0]   req_ext;
  logic [2:0]           win_idx;
  logic                 owner_req, owner_wr, bank_load;
  logic [W-1:0]         lane_sel [N];
  logic [W-1:0]         load_data;

`ifdef DFF_BANK_ARBITER_TIMEOUT_EN
  localparam int HOLD_W = $clog2(MAX_HOLD + 1);
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [N-1:0]      blocked_q, blocked_d;
  logic              timeout_q, timeout_d;
  logic              revoke;
  assign req_eff = req & ~blocked_q;
`else
  assign req_eff = req;
`endif

  // The grant register is one-hot on the owner, so it doubles as the owner mux select.
  assign owner_req = |(req & gnt_q);
  assign owner_wr  = |(wr_en & gnt_q);

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign lane_sel[gi] = gnt_q[gi] ? wr_data[gi*W +: W] : '0;
  end

  // OR-reduce the masked lanes to form the owner's write data.
  always_comb begin
    load_data = '0;
    for (int i = 0; i < N; i++) load_data = load_data | lane_sel[i];
  end

  // Widen the eligible requests into the helper's request space and pick a winner.
  always_comb begin
    req_ext          = '0;
    req_ext[N-1:0]   = req_eff;
    win_idx          = onehot_to_idx(rr_pick(req_ext, ptr_q, N));
  end

  // FSM next state, grant, pointer and bank load.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    bank_load = 1'b0;
`ifdef DFF_BANK_ARBITER_TIMEOUT_EN
    hold_d    = hold_q;
    timeout_d = 1'b0;
    revoke    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        gnt_d = '0;
        if (|req_eff) begin
          gnt_d   = N'(1) << win_idx;
          ptr_d   = 3'((int'(win_idx) + 1) % N);
          state_d = ST_GRANT;
`ifdef DFF_BANK_ARBITER_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      ST_GRANT: begin
        // A write strobed on the releasing/revoking cycle still lands.
        bank_load = owner_wr;
        if (!owner_req) begin
          gnt_d   = '0;
          state_d = ST_RELEASE;
        end
`ifdef DFF_BANK_ARBITER_TIMEOUT_EN
        else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
          gnt_d     = '0;
          timeout_d = 1'b1;
          revoke    = 1'b1;
          state_d   = ST_RELEASE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
`endif
      end
      ST_RELEASE: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef DFF_BANK_ARBITER_TIMEOUT_EN
  // Revoked owner stays blocked until it lets its request drop.
  always_comb begin
    blocked_d = blocked_q & req;
    if (revoke) blocked_d = blocked_d | gnt_q;
  end

  // Timeout bookkeeping registers.
  always_ff @(posedge Clk) begin
    if (rst) begin
      hold_q    <= '0;
      blocked_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      blocked_q <= blocked_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  // Arbiter state registers.
  always_ff @(posedge Clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
    end
  end

  dff_bank_reg #(.W(W)) u_bank (
    .Clk  (Clk),
    .rst  (rst),
    .load (bank_load),
    .d    (load_data),
    .Q    (Q)
  );

  assign gnt  = gnt_q;
  assign busy = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// tb_dff_bank_arbiter: directed scoreboard bench for dff_bank_arbiter (N=4, W=8, MAX_HOLD=4).
module tb_dff_bank_arbiter;

  logic        Clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  wr_en;
  logic [31:0] wr_data;
  logic [3:0]  gnt;
  logic [7:0]  Q;
  logic        busy;
  logic        timeout;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [7:0] q;
    logic       busy;
    logic       tmo;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  dff_bank_arbiter #(.N(4), .W(8), .MAX_HOLD(4)) dut (
    .Clk     (Clk),
    .rst     (rst),
    .req     (req),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .gnt     (gnt),
    .Q       (Q),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog expired");
  end

  // Push the expectation for the coming edge, advance one cycle, then pop and compare.
  task automatic cyc(input string tag, input logic [3:0] g, input logic [7:0] q,
                     input logic b, input logic t);
    exp_t e;
    e.tag = tag; e.gnt = g; e.q = q; e.busy = b; e.tmo = t;
    sb.push_back(e);
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    vectors++;
    $display("%-10s req=%b wr_en=%b gnt=%b Q=%h busy=%b timeout=%b",
             e.tag, req, wr_en, gnt, Q, busy, timeout);
    assert (gnt === e.gnt) else begin
      miscompares++;
      $error("FAIL %s gnt: got %b expected %b", e.tag, gnt, e.gnt);
    end
    assert (Q === e.q) else begin
      miscompares++;
      $error("FAIL %s Q: got %h expected %h", e.tag, Q, e.q);
    end
    assert (busy === e.busy) else begin
      miscompares++;
      $error("FAIL %s busy: got %b expected %b", e.tag, busy, e.busy);
    end
    assert (timeout === e.tmo) else begin
      miscompares++;
      $error("FAIL %s timeout: got %b expected %b", e.tag, timeout, e.tmo);
    end
  endtask

  initial begin
    rst = 1'b1; req = 4'b1111; wr_en = 4'b0000; wr_data = '0;

    // Reset held two cycles with all requesting.
    cyc("rst_a", 4'b0000, 8'h00, 1'b0, 1'b0);
    cyc("rst_b", 4'b0000, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    cyc("rst_gnt", 4'b0001, 8'h00, 1'b1, 1'b0);
    req = 4'b0000;
    cyc("rst_rel", 4'b0000, 8'h00, 1'b1, 1'b0);
    cyc("rst_idle", 4'b0000, 8'h00, 1'b0, 1'b0);

    // Single owner write; non-owner strobe ignored.
    req = 4'b0100;
    cyc("s_gnt", 4'b0100, 8'h00, 1'b1, 1'b0);
    wr_en = 4'b0100; wr_data[16 +: 8] = 8'hA5;
    cyc("s_wr", 4'b0100, 8'hA5, 1'b1, 1'b0);
    wr_en = 4'b0001; wr_data[0 +: 8] = 8'h3C;
    cyc("s_nonown", 4'b0100, 8'hA5, 1'b1, 1'b0);
    wr_en = 4'b0000; req = 4'b0000;
    cyc("s_rel", 4'b0000, 8'hA5, 1'b1, 1'b0);
    cyc("s_idle", 4'b0000, 8'hA5, 1'b0, 1'b0);

    // Round robin from a fresh reset: order 0,1,2,3,0.
    rst = 1'b1;
    cyc("rr_rst", 4'b0000, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      logic [3:0] own;
      own = 4'(1 << (i % 4));
      req = 4'b1111;
      cyc("rr_gnt", own, 8'h00, 1'b1, 1'b0);
      cyc("rr_hold", own, 8'h00, 1'b1, 1'b0);
      req = 4'b1111 & ~own;
      cyc("rr_rel", 4'b0000, 8'h00, 1'b1, 1'b0);
      req = 4'b1111;
      cyc("rr_idle", 4'b0000, 8'h00, 1'b0, 1'b0);
    end

    // Release together with a write (ptr now points at requester 1).
    cyc("rw_gnt", 4'b0010, 8'h00, 1'b1, 1'b0);
    req = 4'b1101; wr_en = 4'b0010; wr_data[8 +: 8] = 8'h7E;
    cyc("rw_rel", 4'b0000, 8'h7E, 1'b1, 1'b0);
    wr_en = 4'b0000; req = 4'b1111;
    cyc("rw_dead", 4'b0000, 8'h7E, 1'b0, 1'b0);
    cyc("rw_next", 4'b0100, 8'h7E, 1'b1, 1'b0);

    // Reset in the middle of a grant with a write pending.
    req = 4'b1011;
    cyc("rm_rel", 4'b0000, 8'h7E, 1'b1, 1'b0);
    req = 4'b1000;
    cyc("rm_idle", 4'b0000, 8'h7E, 1'b0, 1'b0);
    cyc("rm_gnt", 4'b1000, 8'h7E, 1'b1, 1'b0);
    wr_en = 4'b1000; wr_data[24 +: 8] = 8'h55;
    cyc("rm_wr", 4'b1000, 8'h55, 1'b1, 1'b0);
    rst = 1'b1; wr_data[24 +: 8] = 8'hAA;
    cyc("rm_rst", 4'b0000, 8'h00, 1'b0, 1'b0);
    rst = 1'b0; wr_en = 4'b0000; req = 4'b1111;
    cyc("rm_ptr0", 4'b0001, 8'h00, 1'b1, 1'b0);
    req = 4'b0000;
    cyc("rm_rel2", 4'b0000, 8'h00, 1'b1, 1'b0);
    cyc("rm_idle2", 4'b0000, 8'h00, 1'b0, 1'b0);

`ifdef DFF_BANK_ARBITER_TIMEOUT_EN
    // Timeout after MAX_HOLD=4 grant cycles; revoked requester stays blocked.
    req = 4'b1000;
    cyc("to_g1", 4'b1000, 8'h00, 1'b1, 1'b0);
    cyc("to_g2", 4'b1000, 8'h00, 1'b1, 1'b0);
    cyc("to_g3", 4'b1000, 8'h00, 1'b1, 1'b0);
    cyc("to_g4", 4'b1000, 8'h00, 1'b1, 1'b0);
    wr_en = 4'b1000; wr_data[24 +: 8] = 8'hC3;
    cyc("to_rev", 4'b0000, 8'hC3, 1'b1, 1'b1);
    wr_en = 4'b0000; req = 4'b1001;
    cyc("to_idle", 4'b0000, 8'hC3, 1'b0, 1'b0);
    cyc("to_next", 4'b0001, 8'hC3, 1'b1, 1'b0);
    req = 4'b1000;
    cyc("to_rel", 4'b0000, 8'hC3, 1'b1, 1'b0);
    cyc("to_idle2", 4'b0000, 8'hC3, 1'b0, 1'b0);
    cyc("to_blk", 4'b0000, 8'hC3, 1'b0, 1'b0);
    req = 4'b0000;
    cyc("to_drop", 4'b0000, 8'hC3, 1'b0, 1'b0);
    req = 4'b1000;
    cyc("to_regnt", 4'b1000, 8'hC3, 1'b1, 1'b0);
`else
    // Without the timeout a held request keeps its grant indefinitely.
    req = 4'b1000;
    for (int i = 0; i < 6; i++) begin
      cyc("hold", 4'b1000, 8'h00, 1'b1, 1'b0);
    end
    req = 4'b0000;
    cyc("hold_rel", 4'b0000, 8'h00, 1'b1, 1'b0);
    cyc("hold_idle", 4'b0000, 8'h00, 1'b0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dff_bank_arbiter.md
# dff_bank_arbiter

Round-robin arbiter and sequencer for a shared W-bit register bank built from D flip-flops. Up to N requesters compete for write ownership through a req/gnt handshake. The granted requester loads the bank through its own write port; every requester reads the bank output `Q` at all times. The block sits between the requester clusters and the flip-flop storage, and it is the only path by which the bank is written.

## Interface
Parameters:
- `N`, 4: number of requesters (2..8).
- `W`, 8: bank width in bits.
- `MAX_HOLD`, 16: maximum grant length in cycles; used only with the timeout feature.

Ports:
- `Clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N  per-requester ownership request; held high for as long as ownership is wanted.
- `wr_en`  in  N  per-requester write strobe; honoured only while that requester is granted.
- `wr_data`  in  N*W  flattened write data; requester i uses bits [i*W +: W].
- `gnt`  out  N  one-hot grant, registered; all zeros when no requester owns the bank.
- `Q`  out  W  bank contents, registered.
- `busy`  out  1  high in GRANT and RELEASE.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by the timeout; tied 0 when the feature is compiled out.

## Operation
- State machine has three states: IDLE, GRANT, RELEASE.
- IDLE:
  - If any `req` bit is high, pick the first requester at or after `ptr` in round-robin order (wrapping N-1 to 0).
  - Set `gnt` for that requester and go to GRANT.
  - `ptr` becomes winner+1 mod N.
  - If no `req` bit is high, stay in IDLE; `ptr` is unchanged.
- GRANT:
  - While `req[owner]` stays high, remain in GRANT.
  - If `wr_en[owner]` is high, the bank loads `wr_data[owner]`.
  - `wr_en` from non-owners is ignored.
  - When `req[owner]` is sampled low, clear `gnt` and go to RELEASE.
- RELEASE: one dead cycle with no grant; then go to IDLE unconditionally. Requests arriving here wait for IDLE.
- Bank writes are full-width; there is no byte enable and no arithmetic.
- `Q` holds its value whenever no write is honoured.
- Simultaneous events:
  - `req[owner]` low together with `wr_en[owner]` high in the same cycle: the write is honoured, then the grant is released.
  - Several requesters rising in the same IDLE cycle: resolved by `ptr` only.
- Reset mid-operation, synchronous:
  - `gnt`=0, `Q`=0, `busy`=0, `timeout`=0.
  - State is IDLE and `ptr`=0.
  - Any pending write is dropped.

## Timing
- Grant latency:
  - `req[i]` sampled high in IDLE at edge k gives `gnt[i]` high after edge k, i.e. visible in cycle k+1.
  - Minimum request-to-grant time is 1 cycle.
- Write latency: `wr_en[i]`=1 with `gnt[i]`=1 at edge k makes `Q` equal to `wr_data[i]` from cycle k+1.
- Release:
  - `req[owner]` sampled low at edge k: `gnt` reads 0 from cycle k+1 (RELEASE).
  - IDLE is reached at k+2; the next grant can be visible at k+3.
- Turnaround between owners is at least 2 cycles with no grant in between.
- Worst-case wait for requester i with all N requesting and no timeout is (N-1) grant periods plus their turnarounds.

## Configuration
- Macro: `DFF_BANK_ARBITER_TIMEOUT_EN`.
- Defined:
  - A hold counter of clog2(MAX_HOLD+1) bits clears on grant and increments each GRANT cycle.
  - When the owner has held for MAX_HOLD cycles, `gnt` is cleared and `timeout` pulses for 1 cycle; the state goes to RELEASE.
  - A write strobed on the revoking cycle is still honoured.
  - The revoked requester is not granted again until it has dropped `req` for at least one cycle. A per-requester `blocked` mask is set on revoke and cleared when `req` goes low.
- Not defined:
  - No counter and no mask.
  - Grants last until release.
  - `timeout` is constant 0.

## Structure
- Package `dff_bank_arbiter_pkg` holds:
  - the state enum (IDLE, GRANT, RELEASE);
  - a round-robin pick function (req vector, ptr gives one-hot winner);
  - a onehot-to-index function.
- Sub-module `dff_bank_reg`: a W-bit D flip-flop bank with `Clk`, `rst`, load enable and data in, and `Q` out. The arbiter drives its load from the owner mux.

## Test plan
- Reset: assert `rst` for 2 cycles while `req`=4'b1111 → `gnt`=0, `Q`=8'h00, `busy`=0 throughout; after release, `gnt`=4'b0001 one cycle later.
- Single owner write: `req[2]`=1 → `gnt`=4'b0100 next cycle; then `wr_en[2]`=1 with data 8'hA5 → `Q`=8'hA5 the following cycle; a non-owner `wr_en[0]` with 8'h3C in the same window leaves `Q`=8'hA5.
- Round-robin fairness: hold `req`=4'b1111, each owner releases after 2 cycles → grant order 0,1,2,3,0 with exactly 2 idle/release cycles between grants.
- Release with write: on the same cycle `req[1]` falls with `wr_en[1]`=1 and 8'h7E → `Q`=8'h7E and `gnt`=0 next cycle; the next grant appears 2 cycles later.
- Reset mid-grant: `gnt`=4'b1000 with `Q`=8'h55; `rst` pulses one cycle together with a write → `Q`=8'h00, `gnt`=0, and `ptr` restarts at 0.
- Timeout (macro defined, MAX_HOLD=4): `req[3]` held high → `gnt[3]` for exactly 4 cycles, then `timeout` pulses; `req[3]` is not regranted while high; `req[0]` is granted next.
